// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store port and data_memory.
// Loads hit in zero cycles; misses fetch a 16-byte line. Stores always go through to memory.
//   state | meaning
//   IDLE  | serve load hits, accept new requests
//   FILL  | block read of the missing line
//   WRITE | single 64-bit store to memory, update line on hit
module dcache_controller #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  cpu_addr,
  input  logic [63:0]  cpu_wdata,
  input  logic         cpu_read,
  input  logic         cpu_write,
  output logic [63:0]  cpu_rdata,
  output logic         cpu_stall,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_write_data,
  output logic         mem_write,
  output logic         mem_read,
  input  logic [127:0] block_read_data,
  input  logic         mem_ready,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e               state_q, state_d;
  logic [31:3]          addr_q, addr_d;
  logic [63:0]          wdata_q, wdata_d;
  logic [1:0]           wait_q, wait_d;
  logic [15:0]          hit_q, hit_d, miss_q, miss_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0] tag_mem  [NUM_LINES];
  logic [127:0]     data_mem [NUM_LINES];

  logic [31:3]      lk_addr;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_word;
  logic             lk_hit;
  logic [63:0]      lk_data;
  logic             fill_we, word_we;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[2:0];

  // IDLE looks up the live CPU address; FILL and WRITE work on the latched one.
  assign lk_addr = (state_q == IDLE) ? cpu_addr[31:3] : addr_q;
  assign lk_idx  = lk_addr[IDX_W+3:4];
  assign lk_tag  = lk_addr[31:IDX_W+4];
  assign lk_word = lk_addr[3];
  assign lk_hit  = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_data = lk_word ? data_mem[lk_idx][127:64] : data_mem[lk_idx][63:0];

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[lk_idx] <= block_read_data;
      tag_mem[lk_idx]  <= lk_tag;
    end else if (word_we) begin
      if (lk_word) data_mem[lk_idx][127:64] <= wdata_q;
      else         data_mem[lk_idx][63:0]   <= wdata_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wait_d         = wait_q;
    hit_d          = hit_q;
    miss_d         = miss_q;
    valid_d        = valid_q;
    cpu_stall      = 1'b0;
    cpu_rdata      = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    fill_we        = 1'b0;
    word_we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          cpu_stall = 1'b1;
          addr_d    = cpu_addr[31:3];
          wdata_d   = cpu_wdata;
          state_d   = WRITE;
        end else if (cpu_read) begin
          if (lk_hit) begin
            cpu_rdata = lk_data;
            hit_d     = hit_q + 16'd1;
          end else begin
            cpu_stall = 1'b1;
            addr_d    = cpu_addr[31:3];
            miss_d    = miss_q + 16'd1;
            wait_d    = 2'd0;
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        mem_read    = 1'b1;
        mem_address = {addr_q[31:4], 4'b0000};
        cpu_stall   = 1'b1;
        // Holding at 2 lets a slow mem_ready still qualify; earlier pulses are a previous fill's tail.
        if (wait_q != 2'd2) wait_d = wait_q + 2'd1;
        if (mem_ready && (wait_q == 2'd2)) begin
          fill_we         = 1'b1;
          valid_d[lk_idx] = 1'b1;
          state_d         = IDLE;
        end
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = {addr_q, 3'b000};
        mem_write_data = wdata_q;
        word_we        = lk_hit;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: loads and stores push expected responses,
// a negedge monitor compares load data and memory stores as the DUT presents them.
module tb_dcache_controller;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cpu_addr;
  logic [63:0]  cpu_wdata;
  logic         cpu_read, cpu_write;
  logic [63:0]  cpu_rdata;
  logic         cpu_stall;
  logic [31:0]  mem_address;
  logic [63:0]  mem_write_data;
  logic         mem_write, mem_read;
  logic [127:0] block_read_data;
  logic         mem_ready;
  logic [15:0]  hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] rq[$];
  logic [95:0] wq[$];
  logic [63:0] mon_r;
  logic [95:0] mon_w;

  logic [7:0] mem [0:1023];
  logic [2:0] hist;

  always #5 clk = ~clk;

  dcache_controller #(.NUM_LINES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read(mem_read), .block_read_data(block_read_data), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Memory: registered block data, mem_ready lingers for three cycles after mem_read drops.
  initial begin
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      mem[i] = (a[7:0] - 8'h40) ^ {a[9:8], 6'b0};
    end
    hist = '0;
    block_read_data = '0;
  end

  always @(posedge clk) begin
    if (mem_write)
      for (int k = 0; k < 8; k++) mem[{mem_address[9:3], 3'b000} + 10'(k)] <= mem_write_data[8*k +: 8];
    if (mem_read)
      for (int k = 0; k < 16; k++) block_read_data[8*k +: 8] <= mem[{mem_address[9:4], 4'b0000} + 10'(k)];
    hist <= {hist[1:0], mem_read};
  end
  assign mem_ready = |hist;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_read && !cpu_stall) begin
        if (rq.size() == 0) chk("unexpected_load_response", 64'd1, 64'd0);
        else begin
          mon_r = rq.pop_front();
          chk("load_data", cpu_rdata, mon_r);
        end
      end
      if (mem_write) begin
        if (wq.size() == 0) chk("unexpected_mem_write", 64'd1, 64'd0);
        else begin
          mon_w = wq.pop_front();
          chk("store_address", {32'd0, mem_address}, {32'd0, mon_w[95:64]});
          chk("store_data", mem_write_data, mon_w[63:0]);
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [63:0] exp, input int exp_stall);
    int st, mr;
    logic [31:0] ma;
    bit done;
    rq.push_back(exp);
    cpu_addr = a; cpu_read = 1'b1;
    st = 0; mr = 0; ma = '0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_read) begin mr++; ma = mem_address; end
      if (!cpu_stall) done = 1'b1;
      else st++;
    end
    chk("load_completed", 64'(done), 64'd1);
    chk("load_stall_cycles", 64'(st), 64'(exp_stall));
    chk("load_mem_read_cycles", 64'(mr), (exp_stall == 0) ? 64'd0 : 64'd3);
    if (exp_stall != 0) chk("fill_address", {32'd0, ma}, {32'd0, a[31:4], 4'b0000});
    @(posedge clk); #1;
    cpu_read = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [63:0] d);
    int st;
    bit done;
    wq.push_back({a[31:3], 3'b000, d});
    cpu_addr = a; cpu_wdata = d; cpu_write = 1'b1;
    st = 0; done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (!cpu_stall) done = 1'b1;
      else st++;
    end
    chk("store_completed", 64'(done), 64'd1);
    chk("store_stall_cycles", 64'(st), 64'd1);
    @(posedge clk); #1;
    cpu_write = 1'b0;
  endtask

  task automatic chk_counts(input int h, input int m);
    chk("hit_count", {48'd0, hit_count}, 64'(h));
    chk("miss_count", {48'd0, miss_count}, 64'(m));
  endtask

  initial begin
    rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_read", {63'd0, mem_read}, 64'd0);
    chk("reset_mem_write", {63'd0, mem_write}, 64'd0);
    chk("reset_mem_address", {32'd0, mem_address}, 64'd0);
    chk("reset_mem_write_data", mem_write_data, 64'd0);
    chk("reset_cpu_rdata", cpu_rdata, 64'd0);
    chk("reset_cpu_stall_idle", {63'd0, cpu_stall}, 64'd0);
    chk_counts(0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_load(32'h40, 64'h0706050403020100, 4);
    chk_counts(1, 1);
    do_load(32'h48, 64'h0F0E0D0C0B0A0908, 0);
    chk_counts(2, 1);
    do_store(32'h48, 64'hDEADBEEF_CAFEF00D);
    do_load(32'h48, 64'hDEADBEEF_CAFEF00D, 0);
    do_store(32'h300, 64'h0123456789ABCDEF);
    do_load(32'h300, 64'h0123456789ABCDEF, 4);
    chk_counts(4, 2);

    // Same-index misses back to back: each fill starts while the previous mem_ready tail is high.
    do_load(32'h140, 64'h4746454443424140, 4);
    do_load(32'h40,  64'h0706050403020100, 4);
    do_load(32'h148, 64'h4F4E4D4C4B4A4948, 4);
    do_load(32'h40,  64'h0706050403020100, 4);
    do_load(32'h48,  64'hDEADBEEF_CAFEF00D, 0);
    chk_counts(9, 6);

    // Abandon a fill with reset in its second FILL cycle.
    cpu_addr = 32'h140; cpu_read = 1'b1;
    @(negedge clk);
    chk("miss_stall", {63'd0, cpu_stall}, 64'd1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("fill_mem_read_before_reset", {63'd0, mem_read}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_fill_mem_read", {63'd0, mem_read}, 64'd0);
    chk("reset_mid_fill_mem_address", {32'd0, mem_address}, 64'd0);
    chk("reset_mid_fill_rdata", cpu_rdata, 64'd0);
    chk_counts(0, 0);
    cpu_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_load(32'h40,  64'h0706050403020100, 4);
    do_load(32'h140, 64'h4746454443424140, 4);
    chk_counts(2, 2);

    repeat (2) @(posedge clk);
    chk("pending_loads", 64'(rq.size()), 64'd0);
    chk("pending_stores", 64'(wq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
